rf_writeback_arbiter: RTL and testbench

//  Drives the single write port (reg_write/write_addr/write_data) of the 32x32 register file.

---
 rtl/rf_writeback_arbiter.sv | 139 +++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Write-port arbiter for the 32x32 register file. Pipeline writeback always wins.
// Long-latency results wait in a small FIFO, and a busy scoreboard tracks their destinations.
module rf_writeback_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_addr,
  input  logic [31:0]                wb_data,
  input  logic                       lu_valid,
  output logic                       lu_ready,
  input  logic [4:0]                 lu_addr,
  input  logic [31:0]                lu_data,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_addr,
  output logic                       reg_write,
  output logic [4:0]                 write_addr,
  output logic [31:0]                write_data,
  output logic [31:0]                busy,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       err_waw
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        busy_q, busy_d;
  logic               err_q, err_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         write_addr_q, write_addr_d;
  logic [31:0]        write_data_q, write_data_d;

  entry_t head;
  logic   push;
  logic   pop;
  logic   empty;

  assign empty    = (count_q == '0);
  assign lu_ready = (count_q != CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign push     = lu_valid && lu_ready;
  // The FIFO only drains in cycles the pipeline leaves the write port free.
  assign pop      = !wb_valid && !empty;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    busy_d       = busy_q;
    err_d        = err_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wb_valid) begin
      reg_write_d  = (wb_addr != 5'd0);
      write_addr_d = wb_addr;
      write_data_d = wb_data;
    end else if (pop) begin
      reg_write_d  = (head.addr != 5'd0);
      write_addr_d = head.addr;
      write_data_d = head.data;
    end

    // Clear first, then set, so a re-issue in the pop cycle keeps the register busy.
    if (pop) begin
      busy_d[head.addr] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if (wb_valid && busy_q[wb_addr] && (wb_addr != 5'd0)) begin
      err_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // NOTE: FIFO storage has no reset; the flushed count and pointers keep stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: lu_addr, data: lu_data};
    end
  end

  assign reg_write  = reg_write_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign err_waw    = err_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: a per-cycle vector table plus
// hand-written sequences for the FIFO-full and mid-traffic reset cases.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_addr = '0;
  logic [31:0] lu_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_addr = '0;
  logic        reg_write;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [31:0] busy;
  logic [2:0]  fifo_count;
  logic        err_waw;

  int total = 0;
  int bad   = 0;

  rf_writeback_arbiter #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .reg_write(reg_write), .write_addr(write_addr), .write_data(write_data),
    .busy(busy), .fifo_count(fifo_count), .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wbv;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        luv;
    logic [4:0]  lua;
    logic [31:0] lud;
    logic        iv;
    logic [4:0]  ia;
    logic        e_rw;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                     input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                     input logic iv, input logic [4:0] ia,
                     input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [31:0] b, input logic [2:0] c, input logic rdy, input logic err);
    vec_t v;
    v.rst = r; v.wbv = wbv; v.wba = wba; v.wbd = wbd;
    v.luv = luv; v.lua = lua; v.lud = lud; v.iv = iv; v.ia = ia;
    v.e_rw = rw; v.e_wa = wa; v.e_wd = wd; v.e_busy = b;
    v.e_cnt = c; v.e_rdy = rdy; v.e_err = err;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic wbv, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic luv, input logic [4:0] lua, input logic [31:0] lud,
                       input logic iv, input logic [4:0] ia);
    rst = r; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    lu_valid = luv; lu_addr = lua; lu_data = lud;
    issue_valid = iv; issue_addr = ia;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // rst wbv wba wbd | luv lua lud | iv ia || rw wa wd busy cnt rdy err
    add(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 0, 32'h0,        32'h0,   0, 1, 0);
    add(0, 1, 5, 32'hAAAA0001, 0, 0, 32'h0,   0, 0,  1, 5, 32'hAAAA0001, 32'h0,   0, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 5, 32'hAAAA0001, 32'h0,   0, 1, 0);
    add(0, 0, 0, 32'h0,        1, 7, 32'h77,  0, 0,  0, 5, 32'hAAAA0001, 32'h0,   1, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 7, 32'h77,       32'h0,   0, 1, 0);
    add(0, 1, 5, 32'h55,       1, 6, 32'h66,  0, 0,  1, 5, 32'h55,       32'h0,   1, 1, 0);
    add(0, 1, 4, 32'h44,       1, 8, 32'h88,  0, 0,  1, 4, 32'h44,       32'h0,   2, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 6, 32'h66,       32'h0,   1, 1, 0);
    add(0, 0, 0, 32'h0,        1, 9, 32'h99,  0, 0,  1, 8, 32'h88,       32'h0,   1, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 9, 32'h99,       32'h0,   0, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 9, 32'h99,       32'h0,   0, 1, 0);
    add(0, 1, 0, 32'h1234,     0, 0, 32'h0,   0, 0,  0, 0, 32'h1234,     32'h0,   0, 1, 0);
    add(0, 0, 0, 32'h0,        1, 0, 32'hDEAD,0, 0,  0, 0, 32'h1234,     32'h0,   1, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 0, 32'hDEAD,     32'h0,   0, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 9,  0, 0, 32'hDEAD,     32'h200, 0, 1, 0);
    add(0, 0, 0, 32'h0,        1, 9, 32'h999, 0, 0,  0, 0, 32'hDEAD,     32'h200, 1, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  1, 9, 32'h999,      32'h0,   0, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 9,  0, 9, 32'h999,      32'h200, 0, 1, 0);
    add(0, 1, 1, 32'h11,       1, 9, 32'hA9,  0, 0,  1, 1, 32'h11,       32'h200, 1, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 9,  1, 9, 32'hA9,       32'h200, 0, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 0,  0, 9, 32'hA9,       32'h200, 0, 1, 0);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   1, 3,  0, 9, 32'hA9,       32'h208, 0, 1, 0);
    add(0, 1, 3, 32'h33,       0, 0, 32'h0,   0, 0,  1, 3, 32'h33,       32'h208, 0, 1, 1);
    add(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,  0, 3, 32'h33,       32'h208, 0, 1, 1);
    add(1, 1, 5, 32'h5,        1, 5, 32'h5,   1, 5,  0, 0, 32'h0,        32'h0,   0, 1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wbv, vecs[i].wba, vecs[i].wbd,
            vecs[i].luv, vecs[i].lua, vecs[i].lud, vecs[i].iv, vecs[i].ia);
      tick();
      check($sformatf("v%0d reg_write", i),  32'(reg_write),  32'(vecs[i].e_rw));
      check($sformatf("v%0d write_addr", i), 32'(write_addr), 32'(vecs[i].e_wa));
      check($sformatf("v%0d write_data", i), write_data,      vecs[i].e_wd);
      check($sformatf("v%0d busy", i),       busy,            vecs[i].e_busy);
      check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      check($sformatf("v%0d lu_ready", i),   32'(lu_ready),   32'(vecs[i].e_rdy));
      check($sformatf("v%0d err_waw", i),    32'(err_waw),    32'(vecs[i].e_err));
    end

    // Fill the FIFO while the pipeline holds the port, then drain in order.
    idle();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 2, 32'(k), 1, 5'(10 + k), 32'h100 + 32'(k), 0, 0);
      tick();
      check($sformatf("full push%0d count", k), 32'(fifo_count), 32'(k + 1));
      check($sformatf("full push%0d lu_ready", k), 32'(lu_ready), (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("full push%0d wb", k), 32'(write_addr), 32'd2);
    end
    drive(0, 1, 2, 32'h9, 1, 14, 32'h104, 0, 0);
    tick();
    check("full blocked count", 32'(fifo_count), 32'd4);
    check("full blocked lu_ready", 32'(lu_ready), 32'd0);
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain%0d reg_write", k), 32'(reg_write), 32'd1);
      check($sformatf("drain%0d addr", k), 32'(write_addr), 32'(10 + k));
      check($sformatf("drain%0d data", k), write_data, 32'h100 + 32'(k));
      check($sformatf("drain%0d count", k), 32'(fifo_count), 32'(3 - k));
      check($sformatf("drain%0d lu_ready", k), 32'(lu_ready), 32'd1);
    end
    tick();
    check("drain done reg_write", 32'(reg_write), 32'd0);

    // Reset held two cycles while traffic continues, with three entries queued.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 32'h1, 1, 5'(20 + k), 32'h200 + 32'(k), 1, 5'(20 + k));
      tick();
    end
    check("pre-reset count", 32'(fifo_count), 32'd3);
    check("pre-reset busy", busy, 32'h0070_0000);
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 1, 32'h1, 1, 23, 32'h3, 1, 23);
      tick();
      check($sformatf("rst%0d count", k), 32'(fifo_count), 32'd0);
      check($sformatf("rst%0d busy", k), busy, 32'h0);
      check($sformatf("rst%0d reg_write", k), 32'(reg_write), 32'd0);
      check($sformatf("rst%0d lu_ready", k), 32'(lu_ready), 32'd1);
    end
    idle();
    tick();
    check("post-rst reg_write", 32'(reg_write), 32'd0);
    check("post-rst count", 32'(fifo_count), 32'd0);
    check("post-rst lu_ready", 32'(lu_ready), 32'd1);
    check("post-rst busy", busy, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
